// File: rtl/button_sequence_capture_pkg.sv
// Shared constants, state encoding and small encode helpers for the
// player-input capture stage.
package button_sequence_capture_pkg;

  localparam int SLOT_W    = 3;
  localparam int MAX_SLOTS = 16;

  localparam logic [2:0] LV_EASY = 3'b001;
  localparam logic [2:0] LV_MID  = 3'b010;
  localparam logic [2:0] LV_HARD = 3'b100;

  localparam logic [4:0] SLOTS_EASY = 5'd8;
  localparam logic [4:0] SLOTS_MID  = 5'd12;
  localparam logic [4:0] SLOTS_HARD = 5'd16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // A malformed level yields a zero target, which the FSM treats as an
  // immediate, empty round.
  function automatic logic [4:0] levelTarget(input logic [2:0] lvl);
    logic [4:0] tgt;
    tgt = 5'd0;
    case (lvl)
      LV_EASY: tgt = SLOTS_EASY;
      LV_MID:  tgt = SLOTS_MID;
      LV_HARD: tgt = SLOTS_HARD;
      default: tgt = 5'd0;
    endcase
    return tgt;
  endfunction

  function automatic logic isOneHot(input logic [7:0] vec);
    return (vec != 8'd0) && ((vec & (vec - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [SLOT_W-1:0] buttonCode(input logic [7:0] vec);
    logic [SLOT_W-1:0] code;
    code = '0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) code = SLOT_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/button_sequence_capture_if.sv
// Round-control and result signals between the display/compare logic and
// the capture stage.
interface button_sequence_capture_if;
  import button_sequence_capture_pkg::*;

  logic                        enable;
  logic [2:0]                  level;
  logic [7:0]                  botton;
  logic [SLOT_W*MAX_SLOTS-1:0] trimmed_inp;
  logic [4:0]                  captured_count;
  logic                        end_signal;
  logic                        timed_out;

  modport master (
    output enable, level, botton,
    input  trimmed_inp, captured_count, end_signal, timed_out
  );

  modport slave (
    input  enable, level, botton,
    output trimmed_inp, captured_count, end_signal, timed_out
  );

endinterface

// File: rtl/button_sequence_capture_debouncer.sv
// Synchronizes and debounces the 8 play buttons and emits a one-cycle
// pulse with the button code for each clean single-button press.
module button_debouncer
  import button_sequence_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic [7:0]        i_botton,
  output logic [7:0]        o_debounced,
  output logic              o_press_valid,
  output logic [SLOT_W-1:0] o_press_code
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]        r_sync1;
  logic [7:0]        r_sync2;
  logic [7:0]        r_cand;
  logic [7:0]        r_deb;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_press_valid;
  logic [SLOT_W-1:0] r_press_code;

  // r_cnt holds how many consecutive cycles r_cand has already been seen, so
  // the update fires on the DEBOUNCE_CYCLES-th identical observation.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_cand        <= '0;
      r_deb         <= '0;
      r_cnt         <= '0;
      r_press_valid <= 1'b0;
      r_press_code  <= '0;
    end else begin
      r_sync1       <= i_botton;
      r_sync2       <= r_sync1;
      r_press_valid <= 1'b0;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= CNT_W'(1);
      end else begin
        if (r_cnt < CNT_MAX) r_cnt <= r_cnt + 1'b1;
        if ((r_cnt >= CNT_MAX) && (r_cand != r_deb)) begin
          r_deb <= r_cand;
          if ((r_deb == 8'd0) && isOneHot(r_cand)) begin
            r_press_valid <= 1'b1;
            r_press_code  <= buttonCode(r_cand);
          end
        end
      end
    end
  end

  assign o_debounced   = r_deb;
  assign o_press_valid = r_press_valid;
  assign o_press_code  = r_press_code;

endmodule

// File: rtl/button_sequence_capture.sv
// Captures the player's debounced button presses into up to 16 3-bit slots
// and signals when the level's count is reached or the player times out.
module button_sequence_capture
  import button_sequence_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int TIMEOUT_CYCLES  = 5000
) (
  input logic                 clk_1,
  input logic                 rst,
  button_sequence_capture_if.slave bus
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [4:0]        r_target;
  logic [4:0]        r_count;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_timed_out;
  logic              r_end;
  logic [SLOT_W-1:0] r_slots [MAX_SLOTS];

  logic [7:0]        w_deb;
  logic              w_press_valid;
  logic [SLOT_W-1:0] w_press_code;

  logic              w_start_round;
  logic              w_store;
  logic              w_timeout_hit;
  logic              w_tmo_run;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_1        (clk_1),
    .rst          (rst),
    .i_botton     (bus.botton),
    .o_debounced  (w_deb),
    .o_press_valid(w_press_valid),
    .o_press_code (w_press_code)
  );

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Dropping enable always wins; in CAPTURE a press beats a coinciding expiry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.enable) begin
          if (levelTarget(bus.level) == 5'd0) w_next_state = DONE;
          else                                w_next_state = ARM;
        end
      end
      ARM: begin
        if (!bus.enable)         w_next_state = IDLE;
        else if (w_deb == 8'd0)  w_next_state = CAPTURE;
      end
      CAPTURE: begin
        if (!bus.enable) begin
          w_next_state = IDLE;
        end else if (w_press_valid) begin
          if ((r_count + 5'd1) == r_target) w_next_state = DONE;
        end else if (r_tmo == TMO_LAST) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (!bus.enable) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_start_round = 1'b0;
    w_store       = 1'b0;
    w_timeout_hit = 1'b0;
    w_tmo_run     = 1'b0;
    case (r_state)
      IDLE: w_start_round = bus.enable;
      ARM:  w_tmo_run     = bus.enable;
      CAPTURE: begin
        w_tmo_run     = bus.enable;
        w_store       = bus.enable && w_press_valid;
        w_timeout_hit = bus.enable && !w_press_valid && (r_tmo == TMO_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      r_target    <= '0;
      r_count     <= '0;
      r_tmo       <= '0;
      r_timed_out <= 1'b0;
      r_end       <= 1'b0;
      for (int k = 0; k < MAX_SLOTS; k++) r_slots[k] <= '0;
    end else begin
      r_end <= (r_state == DONE);
      if (w_start_round) begin
        r_target    <= levelTarget(bus.level);
        r_count     <= '0;
        r_tmo       <= '0;
        r_timed_out <= 1'b0;
        for (int k = 0; k < MAX_SLOTS; k++) r_slots[k] <= '0;
      end else begin
        if (w_store) begin
          r_slots[r_count[3:0]] <= w_press_code;
          r_count               <= r_count + 5'd1;
          r_tmo                 <= '0;
        end else if (w_tmo_run && (r_tmo != TMO_LAST)) begin
          r_tmo <= r_tmo + 1'b1;
        end
        if (w_timeout_hit) r_timed_out <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < MAX_SLOTS; k++) begin : g_pack
    assign bus.trimmed_inp[k*SLOT_W +: SLOT_W] = r_slots[k];
  end

  assign bus.captured_count = r_count;
  assign bus.end_signal     = r_end;
  assign bus.timed_out      = r_timed_out;

endmodule

// File: tb/tb_button_sequence_capture.sv
// Randomized self-checking bench for button_sequence_capture against a
// press-list reference model.
module tb_button_sequence_capture;
  import button_sequence_capture_pkg::*;

  localparam int DEB      = 20;
  localparam int TMO      = 5000;
  localparam int HOLD_MIN = DEB + 6;

  logic clk_1 = 1'b0;
  logic rst   = 1'b0;

  button_sequence_capture_if ifc ();

  button_sequence_capture #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_1(clk_1),
    .rst  (rst),
    .bus  (ifc)
  );

  always #5 clk_1 = ~clk_1;

  int nChecks = 0;
  int nPass   = 0;
  int expCodes[$];
  int expTarget;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nChecks++;
    if (observed === expected) nPass++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_1);
  endtask

  function automatic int targetForLevel(input logic [2:0] lvl);
    case (lvl)
      3'b001:  return 8;
      3'b010:  return 12;
      3'b100:  return 16;
      default: return 0;
    endcase
  endfunction

  function automatic int indexOf(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [47:0] expectedSlots();
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < expCodes.size(); i++) r[3*i +: 3] = 3'(expCodes[i]);
    return r;
  endfunction

  task automatic startRound(input logic [2:0] lvl);
    ifc.level  = lvl;
    ifc.enable = 1'b1;
    expCodes.delete();
    expTarget = targetForLevel(lvl);
    waitCycles(3);
  endtask

  task automatic bounce(input logic [7:0] vec);
    for (int i = 0; i < 10; i++) begin
      ifc.botton = ($urandom_range(0, 1) != 0) ? vec : 8'h00;
      waitCycles(1);
    end
  endtask

  // One press-and-release; the model records it if it is a lone button.
  task automatic applyStimulus(input logic [7:0] vec, input bit withBounce);
    if (withBounce) bounce(vec);
    ifc.botton = vec;
    waitCycles(HOLD_MIN + $urandom_range(0, 12));
    if (withBounce) bounce(vec);
    ifc.botton = 8'h00;
    waitCycles(HOLD_MIN + $urandom_range(0, 12));
    if (($countones(vec) == 1) && (expCodes.size() < expTarget))
      expCodes.push_back(indexOf(vec));
  endtask

  task automatic checkProgress(input string tag);
    checkOutput({tag, "_count"}, 64'(ifc.captured_count), 64'(expCodes.size()));
    checkOutput({tag, "_slots"}, 64'(ifc.trimmed_inp), 64'(expectedSlots()));
    checkOutput({tag, "_end"}, 64'(ifc.end_signal),
                64'(expCodes.size() == expTarget));
  endtask

  task automatic finishRound(input string tag, input bit expTimeout);
    int waited;
    waited = 0;
    while (!ifc.end_signal && (waited < TMO + 300)) begin
      waitCycles(1);
      waited++;
    end
    checkOutput({tag, "_end"}, 64'(ifc.end_signal), 64'd1);
    checkOutput({tag, "_count"}, 64'(ifc.captured_count), 64'(expCodes.size()));
    checkOutput({tag, "_slots"}, 64'(ifc.trimmed_inp), 64'(expectedSlots()));
    checkOutput({tag, "_timed_out"}, 64'(ifc.timed_out), 64'(expTimeout));
    if (expTimeout) checkOutput({tag, "_not_early"}, 64'(waited >= TMO - 300), 64'd1);
    ifc.enable = 1'b0;
    waitCycles(2);
    checkOutput({tag, "_end_clear"}, 64'(ifc.end_signal), 64'd0);
    checkOutput({tag, "_slots_held"}, 64'(ifc.trimmed_inp), 64'(expectedSlots()));
  endtask

  initial begin
    #(10 * 120000);
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t1Buttons[8];
    logic [7:0] vec;
    logic [2:0] lvl;
    logic [2:0] lvlChoices[3];
    bit wantTimeout;
    int iter;

    t1Buttons  = '{3, 1, 8, 2, 2, 5, 7, 4};
    lvlChoices = '{3'b001, 3'b010, 3'b100};
    ifc.enable = 1'b0;
    ifc.level  = 3'b000;
    ifc.botton = 8'h00;
    rst        = 1'b0;
    waitCycles(3);
    checkOutput("rst_slots", 64'(ifc.trimmed_inp), 64'd0);
    checkOutput("rst_count", 64'(ifc.captured_count), 64'd0);
    checkOutput("rst_end", 64'(ifc.end_signal), 64'd0);
    checkOutput("rst_timed_out", 64'(ifc.timed_out), 64'd0);
    rst = 1'b1;
    waitCycles(2);

    $display("[TB] easy level, fixed button sequence");
    startRound(3'b001);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'(1 << (t1Buttons[i] - 1)), 1'b0);
      checkProgress("t1");
    end
    checkOutput("t1_literal", 64'(ifc.trimmed_inp[23:0]), 64'o36411702);
    checkOutput("t1_upper_zero", 64'(ifc.trimmed_inp[47:24]), 64'd0);
    finishRound("t1", 1'b0);

    $display("[TB] hard level, bouncy presses");
    startRound(3'b100);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'(1 << $urandom_range(0, 7)), 1'b1);
      checkProgress("t2");
    end
    finishRound("t2", 1'b0);

    $display("[TB] mid level, chord then single");
    startRound(3'b010);
    applyStimulus(8'b0001_0010, 1'b0);
    applyStimulus(8'b0010_0000, 1'b0);
    checkProgress("t3");
    checkOutput("t3_slot0", 64'(ifc.trimmed_inp[2:0]), 64'd5);
    ifc.enable = 1'b0;
    waitCycles(3);
    checkOutput("t3_abort_end", 64'(ifc.end_signal), 64'd0);

    $display("[TB] timeout after three presses");
    startRound(3'b001);
    for (int i = 0; i < 3; i++) applyStimulus(8'(1 << $urandom_range(0, 7)), 1'b0);
    checkProgress("t4");
    finishRound("t4", 1'b1);

    $display("[TB] button held across round start");
    ifc.botton = 8'b0000_1000;
    waitCycles(DEB + 10);
    startRound(3'b001);
    waitCycles(30);
    checkOutput("t5_held_count", 64'(ifc.captured_count), 64'd0);
    ifc.botton = 8'h00;
    waitCycles(HOLD_MIN);
    checkOutput("t5_release_count", 64'(ifc.captured_count), 64'd0);
    applyStimulus(8'b0000_1000, 1'b0);
    checkProgress("t5");
    checkOutput("t5_slot0", 64'(ifc.trimmed_inp[2:0]), 64'd3);
    ifc.enable = 1'b0;
    waitCycles(3);

    $display("[TB] reset mid-capture");
    startRound(3'b100);
    for (int i = 0; i < 5; i++) applyStimulus(8'(1 << $urandom_range(0, 7)), 1'b0);
    checkProgress("t6_pre");
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_slots", 64'(ifc.trimmed_inp), 64'd0);
    checkOutput("t6_rst_count", 64'(ifc.captured_count), 64'd0);
    checkOutput("t6_rst_end", 64'(ifc.end_signal), 64'd0);
    checkOutput("t6_rst_timed_out", 64'(ifc.timed_out), 64'd0);
    waitCycles(2);
    ifc.enable = 1'b0;
    rst        = 1'b1;
    waitCycles(2);
    startRound(3'b010);
    vec = 8'(1 << $urandom_range(0, 7));
    applyStimulus(vec, 1'b0);
    checkProgress("t6_post");
    ifc.enable = 1'b0;
    waitCycles(3);

    $display("[TB] malformed level");
    ifc.level  = 3'b011;
    ifc.enable = 1'b1;
    waitCycles(2);
    checkOutput("t7_end", 64'(ifc.end_signal), 64'd1);
    checkOutput("t7_count", 64'(ifc.captured_count), 64'd0);
    checkOutput("t7_timed_out", 64'(ifc.timed_out), 64'd0);
    ifc.enable = 1'b0;
    waitCycles(3);

    $display("[TB] randomized rounds");
    for (int r = 0; r < 3; r++) begin
      lvl         = lvlChoices[$urandom_range(0, 2)];
      wantTimeout = (r == 1);
      startRound(lvl);
      iter = 0;
      while ((expCodes.size() < expTarget) && (iter < 60)) begin
        if (wantTimeout && (expCodes.size() >= expTarget - 2)) break;
        if ($urandom_range(0, 4) == 0) vec = 8'($urandom);
        else                           vec = 8'(1 << $urandom_range(0, 7));
        applyStimulus(vec, bit'($urandom_range(0, 1)));
        checkProgress("rnd");
        iter++;
      end
      finishRound("rnd", expCodes.size() < expTarget);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
